// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
package hazard_pkg;

    // Widest register address the scoreboard entry can hold; narrower
    // addresses are zero-extended into it.
    localparam int HZ_RD_W = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    // One in-flight instruction tracked after ID.
    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               regwr;
        logic               load;
    } hazard_sb_entry_t;

    // Width of a forward select for a scoreboard of the given depth.
    function automatic int sel_w(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/hazard_fwd_pick.sv
// Per-operand forwarding search: finds the youngest in-flight producer of a
// source register and decides whether its result can be forwarded yet.
module hazard_fwd_pick
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int SEL_W    = sel_w(DEPTH)
) (
    input  hazard_sb_entry_t [DEPTH-1:0] i_sb,
    input  logic [HZ_RD_W-1:0]           i_src,
    output logic                         o_hit,
    output logic                         o_ready,
    output logic [SEL_W-1:0]             o_sel
);

    logic w_found;
    logic w_load;
    int   w_idx;
    logic w_ready;

    // Priority search from entry 0 so the youngest matching producer wins.
    always_comb begin
        w_found = 1'b0;
        w_load  = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_found && i_sb[k].valid && i_sb[k].regwr &&
                (i_sb[k].rd != HZ_RD_W'(0)) && (i_sb[k].rd == i_src)) begin
                w_found = 1'b1;
                w_load  = i_sb[k].load;
                w_idx   = k;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Readiness and select: loads need LOAD_RDY stages, the last entry is
    // covered by the register file write-to-read bypass.
    always_comb begin
        o_hit = w_found;
        if (w_found && w_load && ((w_idx + 1) < LOAD_RDY)) begin
            w_ready = 1'b0;
        end else begin
            w_ready = w_found;
        end
        o_ready = w_ready;
        if (w_ready && ((w_idx + 1) <= (DEPTH - 1))) begin
            o_sel = SEL_W'(w_idx + 1);
        end else begin
            o_sel = SEL_W'(FWD_REGFILE);
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight
// destinations, registered EX forward selects, load-use stall and a
// saturating stall counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [AW-1:0]             id_rs,
    input  logic [AW-1:0]             id_rt,
    input  logic [AW-1:0]             id_rd,
    input  logic                      id_regwr,
    input  logic                      id_load,
    output logic                      stall,
    output logic [sel_w(DEPTH)-1:0]   ex_fwd_a,
    output logic [sel_w(DEPTH)-1:0]   ex_fwd_b,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int SEL_W = sel_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hazard_sb_entry_t [DEPTH-1:0] r_sb;
    logic [SEL_W-1:0]             r_fwd_a;
    logic [SEL_W-1:0]             r_fwd_b;
    logic [CNT_W-1:0]             r_cnt;

    hazard_sb_entry_t w_id_entry;
    logic             w_hit_a, w_ready_a;
    logic             w_hit_b, w_ready_b;
    logic [SEL_W-1:0] w_sel_a, w_sel_b;
    logic             w_stall;
    logic             w_bubble;

    hazard_fwd_pick #(
        .DEPTH    (DEPTH),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_pick_a (
        .i_sb    (r_sb),
        .i_src   (HZ_RD_W'(id_rs)),
        .o_hit   (w_hit_a),
        .o_ready (w_ready_a),
        .o_sel   (w_sel_a)
    );

    hazard_fwd_pick #(
        .DEPTH    (DEPTH),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_pick_b (
        .i_sb    (r_sb),
        .i_src   (HZ_RD_W'(id_rt)),
        .o_hit   (w_hit_b),
        .o_ready (w_ready_b),
        .o_sel   (w_sel_b)
    );

    // Load-use stall and bubble decision; flush overrides a would-be stall.
    always_comb begin
        w_id_entry.valid = id_valid;
        w_id_entry.rd    = HZ_RD_W'(id_rd);
        w_id_entry.regwr = id_regwr;
        w_id_entry.load  = id_load;
        if (!rst && id_valid && !flush &&
            ((w_hit_a && !w_ready_a) || (w_hit_b && !w_ready_b))) begin
            w_stall = 1'b1;
        end else begin
            w_stall = 1'b0;
        end
        w_bubble = !id_valid || flush || w_stall;
    end

    // Scoreboard shift, select registers and stall counter; hold freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb    <= '0;
            r_fwd_a <= SEL_W'(FWD_REGFILE);
            r_fwd_b <= SEL_W'(FWD_REGFILE);
            r_cnt   <= CNT_W'(0);
        end else if (hold) begin
            r_sb    <= r_sb;
            r_fwd_a <= r_fwd_a;
            r_fwd_b <= r_fwd_b;
            r_cnt   <= r_cnt;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_bubble) begin
                r_sb[0] <= '0;
                r_fwd_a <= SEL_W'(FWD_REGFILE);
                r_fwd_b <= SEL_W'(FWD_REGFILE);
            end else begin
                r_sb[0] <= w_id_entry;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end
            if (w_stall && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign stall     = w_stall;
    assign ex_fwd_a  = r_fwd_a;
    assign ex_fwd_b  = r_fwd_b;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized scoreboard bench: two configurations (default, and DEPTH=5 /
// LOAD_RDY=3 / CNT_W=2) share one input stream, each with its own model.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst, hold, flush, id_valid, id_regwr, id_load;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        stall0, stall1;
    logic [1:0]  fa0, fb0;
    logic [15:0] cnt0;
    logic [2:0]  fa1, fb1;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    hazard_forward_unit u_dut0 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_load(id_load), .stall(stall0), .ex_fwd_a(fa0), .ex_fwd_b(fb0),
        .stall_cnt(cnt0)
    );

    hazard_forward_unit #(.AW(5), .DEPTH(5), .LOAD_RDY(3), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_load(id_load), .stall(stall1), .ex_fwd_a(fa1), .ex_fwd_b(fb1),
        .stall_cnt(cnt1)
    );

    // Reference model: per config, the last DEPTH instructions that left ID
    // (index 0 = most recent), plus the expected registered outputs.
    int md[2]   = '{3, 5};
    int mlr[2]  = '{2, 3};
    int mcmx[2] = '{65535, 3};
    int hv[2][8], hrd[2][8], hwr[2][8], hld[2][8];
    int mfa[2], mfb[2], mcnt[2];

    typedef struct {
        int st0, st1, fa0, fb0, c0, fa1, fb1, c1;
    } item_t;
    item_t q[$];

    int checks = 0;
    int errors = 0;
    int stalls_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Age (edges since leaving ID) of the youngest instruction writing src; 0 = none.
    task automatic youngest(input int m, input int src, output int age, output int isld);
        age = 0;
        isld = 0;
        for (int k = 0; k < md[m]; k++) begin
            if (age == 0 && hv[m][k] != 0 && hwr[m][k] != 0 && hrd[m][k] != 0 && hrd[m][k] == src) begin
                age = k + 1;
                isld = hld[m][k];
            end
        end
    endtask

    task automatic model_step(input int m, output int st);
        int aa, la, ab, lb, nra, nrb, bub, sa, sb;
        youngest(m, int'(id_rs), aa, la);
        youngest(m, int'(id_rt), ab, lb);
        nra = (aa != 0 && la != 0 && aa < mlr[m]) ? 1 : 0;
        nrb = (ab != 0 && lb != 0 && ab < mlr[m]) ? 1 : 0;
        st  = (!rst && id_valid && !flush && (nra != 0 || nrb != 0)) ? 1 : 0;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                hv[m][k] = 0; hrd[m][k] = 0; hwr[m][k] = 0; hld[m][k] = 0;
            end
            mfa[m] = 0; mfb[m] = 0; mcnt[m] = 0;
        end else if (!hold) begin
            bub = (!id_valid || flush || st != 0) ? 1 : 0;
            sa = (aa != 0 && nra == 0 && aa < md[m]) ? aa : 0;
            sb = (ab != 0 && nrb == 0 && ab < md[m]) ? ab : 0;
            for (int k = 7; k >= 1; k--) begin
                hv[m][k] = hv[m][k-1]; hrd[m][k] = hrd[m][k-1];
                hwr[m][k] = hwr[m][k-1]; hld[m][k] = hld[m][k-1];
            end
            hv[m][0]  = bub ? 0 : 1;
            hrd[m][0] = int'(id_rd);
            hwr[m][0] = int'(id_regwr);
            hld[m][0] = int'(id_load);
            mfa[m] = bub ? 0 : sa;
            mfb[m] = bub ? 0 : sb;
            if (st != 0 && mcnt[m] < mcmx[m]) mcnt[m] = mcnt[m] + 1;
        end
    endtask

    // Driver: new inputs each negedge, model advanced, expectation queued.
    initial begin
        item_t it;
        int s0, s1;
        rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_regwr = 1'b0; id_load = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst      = (n < 2 || n == 1500 || $urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            hold     = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            flush    = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            id_valid = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
            id_rs    = 5'($urandom_range(0, 7));
            id_rt    = 5'($urandom_range(0, 7));
            id_rd    = 5'($urandom_range(0, 7));
            id_regwr = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
            id_load  = ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0;
            model_step(0, s0);
            model_step(1, s1);
            if (s0 != 0 || s1 != 0) stalls_seen++;
            it.st0 = s0; it.st1 = s1;
            it.fa0 = mfa[0]; it.fb0 = mfb[0]; it.c0 = mcnt[0];
            it.fa1 = mfa[1]; it.fb1 = mfb[1]; it.c1 = mcnt[1];
            q.push_back(it);
        end
        @(negedge clk);
        rst = 1'b0; hold = 1'b1; id_valid = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        chk("stall_activity", (stalls_seen > 20) ? 1 : 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: stall checked mid-cycle, registered outputs just after the edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                it = q[0];
                chk("stall_d3", int'(stall0), it.st0);
                chk("stall_d5", int'(stall1), it.st1);
                @(posedge clk);
                #1;
                chk("fwd_a_d3", int'(fa0), it.fa0);
                chk("fwd_b_d3", int'(fb0), it.fb0);
                chk("cnt_d3", int'(cnt0), it.c0);
                chk("fwd_a_d5", int'(fa1), it.fa1);
                chk("fwd_b_d5", int'(fb1), it.fb1);
                chk("cnt_d5", int'(cnt1), it.c1);
                void'(q.pop_front());
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
